// File: rtl/pic_pkg.sv
// rtl/pic_pkg.sv - shared state type and constants for the picture reader
package pic_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int WORD_STRIDE = 4;
    localparam int BUF_DEPTH   = 4;

endpackage

// File: rtl/pic_fifo.sv
// rtl/pic_fifo.sv - small output buffer between memory reads and the pixel stream
module pic_fifo #(
    parameter int SIZE      = 8,
    parameter int BUF_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               push,
    input  logic [SIZE-1:0]                    push_data,
    input  logic                               pop,
    output logic [SIZE-1:0]                    head_data,
    output logic                               empty,
    output logic [$clog2(BUF_DEPTH+1)-1:0]     count
);

    localparam int AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CW = $clog2(BUF_DEPTH+1);

    logic [SIZE-1:0] storage [BUF_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    // A pop only happens on a non-empty buffer; a push into a full buffer is
    // only taken when the same edge frees a slot.
    always_comb begin
        do_pop    = pop && (count != '0);
        do_push   = push && ((count != CW'(BUF_DEPTH)) || do_pop);
        empty     = (count == '0);
        head_data = storage[rd_ptr];
    end

    // Data slots are not reset; only the pointers and occupancy define contents.
    always_ff @(posedge clk) begin
        if (do_push) begin
            storage[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; push and pop together keep count.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == AW'(BUF_DEPTH-1)) ? '0 : wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == AW'(BUF_DEPTH-1)) ? '0 : rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pic_reader.sv
// rtl/pic_reader.sv - fetches a frame of words from picture memory and streams them out
module pic_reader
    import pic_pkg::*;
#(
    parameter int              SIZE      = 8,
    parameter logic [SIZE-1:0] BASE      = '0,
    parameter int              NUM_WORDS = 9
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic [SIZE-1:0] mem_address,
    input  logic [SIZE-1:0] mem_read,
    output logic [SIZE-1:0] pix_data,
    output logic            pix_valid,
    input  logic            pix_ready,
    output logic            pix_last,
    output logic            busy,
    output logic            done
);

    localparam logic [SIZE-1:0] LAST_IDX = SIZE'(NUM_WORDS - 1);
    localparam logic [SIZE-1:0] STRIDE   = SIZE'(WORD_STRIDE);
    localparam int              CW       = $clog2(BUF_DEPTH+1);

    state_t          state;
    logic [SIZE-1:0] issued;
    logic [SIZE-1:0] popped;
    logic            issue_d0;
    logic            issue_d1;
    logic [CW-1:0]   fifo_count;
    logic            fifo_empty;
    logic [SIZE-1:0] fifo_head;
    logic [3:0]      pending;
    logic            room;
    logic            accept;
    logic            issue;
    logic            xfer;
    logic            final_xfer;

    // issue_d0 marks an address presented this cycle, issue_d1 one whose data
    // is on mem_read now; both count against free buffer slots.
    always_comb begin
        pending    = 4'(fifo_count) + 4'(issue_d0) + 4'(issue_d1);
        room       = (pending < 4'(BUF_DEPTH));
        accept     = (state == IDLE) && start && !done;
        issue      = accept || ((state == FETCH) && room);
        pix_valid  = !fifo_empty;
        pix_data   = fifo_empty ? '0 : fifo_head;
        pix_last   = pix_valid && (popped == LAST_IDX);
        xfer       = pix_valid && pix_ready;
        final_xfer = xfer && pix_last;
        busy       = (state != IDLE);
    end

    pic_fifo #(
        .SIZE      (SIZE),
        .BUF_DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (issue_d1),
        .push_data (mem_read),
        .pop       (xfer),
        .head_data (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Frame FSM, address counter and read pipeline; reset drops in-flight reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            mem_address <= '0;
            issued      <= '0;
            popped      <= '0;
            issue_d0    <= 1'b0;
            issue_d1    <= 1'b0;
            done        <= 1'b0;
        end else begin
            issue_d0 <= issue;
            issue_d1 <= issue_d0;
            done     <= final_xfer;
            if (xfer) begin
                popped <= popped + SIZE'(1);
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        mem_address <= BASE;
                        issued      <= SIZE'(1);
                        popped      <= '0;
                        state       <= (NUM_WORDS == 1) ? DRAIN : FETCH;
                    end
                end
                FETCH: begin
                    if (room) begin
                        mem_address <= mem_address + STRIDE;
                        issued      <= issued + SIZE'(1);
                        if (issued == LAST_IDX) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (final_xfer) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pic_reader.sv
// tb/tb_pic_reader.sv - scoreboard bench for pic_reader against a picture memory model
module tb_pic_reader;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] mem_address;
    logic [7:0] mem_read;
    logic [7:0] pix_data;
    logic       pix_valid;
    logic       pix_ready;
    logic       pix_last;
    logic       busy;
    logic       done;

    logic       start2;
    logic [7:0] mem_address2;
    logic [7:0] mem_read2;
    logic [7:0] pix_data2;
    logic       pix_valid2;
    logic       pix_ready2;
    logic       pix_last2;
    logic       busy2;
    logic       done2;

    logic [7:0] mem_pic [256];
    logic [7:0] frame_words [9] = '{8'hA5, 8'h3C, 8'h5A, 8'hC3, 8'h0F,
                                    8'hF0, 8'h99, 8'h66, 8'h7E};

    logic [8:0] sb1 [$];
    logic [8:0] sb2 [$];
    int passed = 0;
    int total  = 0;
    int xfers  = 0;

    always #5 clk = ~clk;

    pic_reader #(.SIZE(8), .BASE(8'h00), .NUM_WORDS(9)) dut (
        .clk(clk), .reset(reset), .start(start), .mem_address(mem_address),
        .mem_read(mem_read), .pix_data(pix_data), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .pix_last(pix_last), .busy(busy), .done(done)
    );

    pic_reader #(.SIZE(8), .BASE(8'hF8), .NUM_WORDS(4)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .mem_address(mem_address2),
        .mem_read(mem_read2), .pix_data(pix_data2), .pix_valid(pix_valid2),
        .pix_ready(pix_ready2), .pix_last(pix_last2), .busy(busy2), .done(done2)
    );

    // mem_pic: synchronous read, data valid one edge after the address
    always @(posedge clk) begin
        mem_read  <= mem_pic[mem_address];
        mem_read2 <= mem_pic[mem_address2];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame();
        for (int i = 0; i < 9; i++) sb1.push_back({(i == 8), frame_words[i]});
    endtask

    task automatic wait_done(input int limit, output int n);
        n = 0;
        for (int i = 0; i < limit; i++) begin
            step();
            n = i + 1;
            if (done) break;
        end
    endtask

    // Monitor: every transfer on either stream is popped from its scoreboard
    always @(negedge clk) begin
        if (!reset) begin
            if (pix_valid && pix_ready) begin
                if (sb1.size() == 0) begin
                    check("sb1_unexpected_word", {24'd0, pix_data}, 32'hFFFF_FFFF);
                end else begin
                    logic [8:0] e;
                    e = sb1.pop_front();
                    check("pix_data", {24'd0, pix_data}, {24'd0, e[7:0]});
                    check("pix_last", {31'd0, pix_last}, {31'd0, e[8]});
                end
                xfers++;
            end
            if (pix_valid2 && pix_ready2) begin
                if (sb2.size() == 0) begin
                    check("sb2_unexpected_word", {24'd0, pix_data2}, 32'hFFFF_FFFF);
                end else begin
                    logic [8:0] e;
                    e = sb2.pop_front();
                    check("pix_data2", {24'd0, pix_data2}, {24'd0, e[7:0]});
                    check("pix_last2", {31'd0, pix_last2}, {31'd0, e[8]});
                end
            end
            if (done) check("busy_low_in_done", {31'd0, busy}, 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int n;
        int x0;
        for (int i = 0; i < 256; i++) mem_pic[i] = 8'hEE;
        for (int i = 0; i < 9; i++) mem_pic[i*4] = frame_words[i];
        mem_pic[8'hF8] = 8'h11;
        mem_pic[8'hFC] = 8'h22;

        reset = 1'b1; start = 1'b0; pix_ready = 1'b0; start2 = 1'b0; pix_ready2 = 1'b1;
        step(); step();
        check("rst_mem_address", {24'd0, mem_address}, 32'd0);
        check("rst_pix_data",    {24'd0, pix_data},    32'd0);
        check("rst_pix_valid",   {31'd0, pix_valid},   32'd0);
        check("rst_pix_last",    {31'd0, pix_last},    32'd0);
        check("rst_busy",        {31'd0, busy},        32'd0);
        check("rst_done",        {31'd0, done},        32'd0);
        reset = 1'b0;
        step();

        // Scenario 1: streaming with ready held high
        pix_ready = 1'b1;
        x0 = xfers;
        push_frame();
        start = 1'b1;
        step();
        start = 1'b0;
        check("s1_addr_e0",  {24'd0, mem_address}, 32'h00);
        check("s1_busy_e0",  {31'd0, busy},        32'd1);
        check("s1_valid_e0", {31'd0, pix_valid},   32'd0);
        step();
        check("s1_addr_e1",  {24'd0, mem_address}, 32'h04);
        check("s1_valid_e1", {31'd0, pix_valid},   32'd0);
        step();
        check("s1_valid_e2", {31'd0, pix_valid},   32'd1);
        wait_done(30, n);
        check("s1_done_latency", n, 32'd9);
        check("s1_xfers", xfers - x0, 32'd9);
        step();
        check("s1_done_one_cycle", {31'd0, done}, 32'd0);
        check("s1_sb_empty", sb1.size(), 32'd0);

        // Scenario 2: backpressure stalls issue after four reads
        pix_ready = 1'b0;
        push_frame();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (9) step();
        check("s2_addr_stalled", {24'd0, mem_address}, 32'h0C);
        check("s2_valid_held",   {31'd0, pix_valid},   32'd1);
        check("s2_data_held",    {24'd0, pix_data},    32'hA5);
        pix_ready = 1'b1;
        wait_done(40, n);
        check("s2_done", {31'd0, done}, 32'd1);
        check("s2_sb_empty", sb1.size(), 32'd0);
        step();

        // Scenario 3: ready toggling every cycle
        x0 = xfers;
        push_frame();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step();
            pix_ready = ~pix_ready;
            if (done) break;
        end
        check("s3_done", {31'd0, done}, 32'd1);
        check("s3_xfers", xfers - x0, 32'd9);
        check("s3_sb_empty", sb1.size(), 32'd0);
        pix_ready = 1'b1;
        step();

        // Scenario 4: address wrap on the second instance
        sb2.push_back({1'b0, 8'h11});
        sb2.push_back({1'b0, 8'h22});
        sb2.push_back({1'b0, 8'hA5});
        sb2.push_back({1'b1, 8'h3C});
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        check("s4_addr0", {24'd0, mem_address2}, 32'hF8);
        step();
        check("s4_addr1", {24'd0, mem_address2}, 32'hFC);
        step();
        check("s4_addr2", {24'd0, mem_address2}, 32'h00);
        step();
        check("s4_addr3", {24'd0, mem_address2}, 32'h04);
        for (int i = 0; i < 30; i++) begin
            step();
            if (done2) break;
        end
        check("s4_done", {31'd0, done2}, 32'd1);
        check("s4_sb_empty", sb2.size(), 32'd0);
        step();

        // Scenario 5: reset after the third transfer, then replay
        x0 = xfers;
        push_frame();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (xfers - x0 >= 3) break;
            step();
        end
        check("s5_xfers_before_reset", xfers - x0, 32'd3);
        reset = 1'b1;
        step();
        check("s5_mem_address", {24'd0, mem_address}, 32'd0);
        check("s5_pix_data",    {24'd0, pix_data},    32'd0);
        check("s5_pix_valid",   {31'd0, pix_valid},   32'd0);
        check("s5_pix_last",    {31'd0, pix_last},    32'd0);
        check("s5_busy",        {31'd0, busy},        32'd0);
        check("s5_done",        {31'd0, done},        32'd0);
        sb1.delete();
        reset = 1'b0;
        repeat (3) step();
        check("s5_no_stale_data", {31'd0, pix_valid}, 32'd0);
        push_frame();
        start = 1'b1;
        step();
        start = 1'b0;
        check("s5_replay_addr", {24'd0, mem_address}, 32'h00);
        wait_done(40, n);
        check("s5_replay_done", {31'd0, done}, 32'd1);
        check("s5_sb_empty", sb1.size(), 32'd0);
        step();

        // Scenario 6: start held high through the frame and the done cycle
        push_frame();
        start = 1'b1;
        step();
        wait_done(40, n);
        check("s6_done", {31'd0, done}, 32'd1);
        check("s6_sb_empty1", sb1.size(), 32'd0);
        step();
        check("s6_ignored_in_done", {31'd0, busy}, 32'd0);
        push_frame();
        step();
        check("s6_restart_busy", {31'd0, busy}, 32'd1);
        check("s6_restart_addr", {24'd0, mem_address}, 32'h00);
        start = 1'b0;
        wait_done(40, n);
        check("s6_done2", {31'd0, done}, 32'd1);
        step();
        check("s6_sb_empty2", sb1.size(), 32'd0);
        check("s6_idle", {31'd0, busy}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
